// File: rtl/control_regfile_axil.sv
// AXI4-Lite slave register file: RW control words, read-only status words, write-commit pulses.
// Define CONTROL_REGFILE_SLVERR_EN to answer out-of-range accesses and RO writes with SLVERR.
module control_regfile_axil #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 16,
  parameter int NUM_RO             = 4
) (
  input  logic                                             S_AXI_ACLK,
  input  logic                                             S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                    S_AXI_AWADDR,
  input  logic [2:0]                                       S_AXI_AWPROT,
  input  logic                                             S_AXI_AWVALID,
  output logic                                             S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                    S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                  S_AXI_WSTRB,
  input  logic                                             S_AXI_WVALID,
  output logic                                             S_AXI_WREADY,
  output logic [1:0]                                       S_AXI_BRESP,
  output logic                                             S_AXI_BVALID,
  input  logic                                             S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                    S_AXI_ARADDR,
  input  logic [2:0]                                       S_AXI_ARPROT,
  input  logic                                             S_AXI_ARVALID,
  output logic                                             S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                    S_AXI_RDATA,
  output logic [1:0]                                       S_AXI_RRESP,
  output logic                                             S_AXI_RVALID,
  input  logic                                             S_AXI_RREADY,
  output logic [(NUM_REGS-NUM_RO)*C_S_AXI_DATA_WIDTH-1:0]  reg_out,
  output logic [NUM_REGS-NUM_RO-1:0]                       wr_pulse,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*C_S_AXI_DATA_WIDTH-1:0] status_in
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int AW     = C_S_AXI_ADDR_WIDTH;
  localparam int NB     = DW / 8;
  localparam int LSB    = $clog2(NB);
  localparam int IW     = AW - LSB;
  localparam int NUM_RW = NUM_REGS - NUM_RO;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef CONTROL_REGFILE_SLVERR_EN
  localparam logic [1:0] RESP_ERR  = 2'b10;
`else
  localparam logic [1:0] RESP_ERR  = 2'b00;
`endif

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t         w_state;
  rstate_t         r_state;
  logic [DW-1:0]   regs [NUM_RW];
  logic            aw_held, w_held;
  logic [IW-1:0]   aw_idx;
  logic [DW-1:0]   w_data;
  logic [NB-1:0]   w_strb;

  logic            aw_hs, w_hs, do_commit, cmt_rw;
  logic [IW-1:0]   cmt_idx;
  logic [DW-1:0]   cmt_data;
  logic [NB-1:0]   cmt_strb;
  int              cmt_i, ar_i;
  logic [DW-1:0]   rd_word;
  logic [1:0]      rd_resp;
  logic            unused;

  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

  assign S_AXI_AWREADY = !aw_held && !S_AXI_BVALID;
  assign S_AXI_WREADY  = !w_held && !S_AXI_BVALID;
  assign S_AXI_ARREADY = !S_AXI_RVALID;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;

  // A channel handshaking this edge counts as held, so AW+W together commit immediately.
  assign cmt_idx   = aw_held ? aw_idx : S_AXI_AWADDR[AW-1:LSB];
  assign cmt_data  = w_held ? w_data : S_AXI_WDATA;
  assign cmt_strb  = w_held ? w_strb : S_AXI_WSTRB;
  assign do_commit = (aw_held || aw_hs) && (w_held || w_hs) && !S_AXI_BVALID;

  always_comb begin
    cmt_i  = int'(cmt_idx);
    cmt_rw = (cmt_i < NUM_RW);
  end

  always_comb begin
    ar_i    = int'(S_AXI_ARADDR[AW-1:LSB]);
    rd_word = '0;
    for (int i = 0; i < NUM_RW; i++)
      if (ar_i == i) rd_word = regs[i];
    for (int k = 0; k < NUM_RO; k++)
      if (ar_i == NUM_RW + k) rd_word = status_in[k*DW +: DW];
    rd_resp = (ar_i < NUM_REGS) ? RESP_OKAY : RESP_ERR;
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_out
    assign reg_out[g*DW +: DW] = regs[g];
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state      <= W_IDLE;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx       <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      wr_pulse     <= '0;
      for (int i = 0; i < NUM_RW; i++) regs[i] <= '0;
    end else begin
      wr_pulse <= '0;
      case (w_state)
        W_IDLE: begin
          if (do_commit) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= cmt_rw ? RESP_OKAY : RESP_ERR;
            w_state      <= W_RESP;
            for (int i = 0; i < NUM_RW; i++) begin
              if (cmt_i == i) begin
                wr_pulse[i] <= 1'b1;
                for (int b = 0; b < NB; b++)
                  if (cmt_strb[b]) regs[i][b*8 +: 8] <= cmt_data[b*8 +: 8];
              end
            end
          end else begin
            if (aw_hs) begin
              aw_held <= 1'b1;
              aw_idx  <= S_AXI_AWADDR[AW-1:LSB];
            end
            if (w_hs) begin
              w_held <= 1'b1;
              w_data <= S_AXI_WDATA;
              w_strb <= S_AXI_WSTRB;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            w_state      <= W_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state      <= R_IDLE;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (S_AXI_ARVALID) begin
            S_AXI_RDATA  <= rd_word;
            S_AXI_RRESP  <= rd_resp;
            S_AXI_RVALID <= 1'b1;
            r_state      <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
            r_state      <= R_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_regfile_axil.sv
// Scoreboard bench for control_regfile_axil; address width 7 so that 0x40 is out of range.
module tb_control_regfile_axil;
  localparam int DW = 32, AW = 7, NR = 16, NRO = 4, NRW = 12;
`ifdef CONTROL_REGFILE_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [NRW*DW-1:0] reg_out;
  logic [NRW-1:0] wr_pulse;
  logic [NRO*DW-1:0] status_in;

  always #5 clk = ~clk;

  control_regfile_axil #(
    .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .NUM_REGS(NR), .NUM_RO(NRO)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .wr_pulse(wr_pulse), .status_in(status_in)
  );

  int n_checks = 0, n_pass = 0;
  logic [31:0] model [NRW];
  logic [33:0] rq[$];
  logic [1:0]  bq[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [33:0] exp_rd(input int idx);
    if (idx < NRW) return {2'b00, model[idx]};
    if (idx < NR)  return {2'b00, status_in[(idx-NRW)*32 +: 32]};
    return {ERR, 32'h0};
  endfunction

  // Responses are taken #1 after the falling edge, once the driver has settled ready.
  always @(negedge clk) begin
    logic [33:0] e;
    #1;
    if (!rst && rvalid && rready) begin
      if (rq.size() == 0) chk("r_unexpected", 1'b1, 1'b0);
      else begin
        e = rq.pop_front();
        chk("rdata", rdata, e[31:0]);
        chk("rresp", rresp, e[33:32]);
      end
    end
    if (!rst && bvalid && bready) begin
      if (bq.size() == 0) chk("b_unexpected", 1'b1, 1'b0);
      else chk("bresp", bresp, bq.pop_front());
    end
  end

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int b_hold);
    int idx, t;
    logic aw_done, w_done, aw_go, w_go;
    logic [NRW-1:0] p;
    idx = int'(addr[AW-1:2]);
    p = '0;
    if (idx < NRW) begin
      p[idx] = 1'b1;
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
    end
    bq.push_back((idx < NRW) ? 2'b00 : ERR);
    bready = (b_hold == 0);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; t = 0;
    while (!(aw_done && w_done) && t < 20) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      @(posedge clk); @(negedge clk); t++;
      if (aw_go) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_go)  begin wvalid = 1'b0;  w_done = 1'b1;  end
    end
    chk("wr_handshake", aw_done && w_done, 1'b1);
    chk("bvalid_latency", bvalid, 1'b1);
    chk("wr_pulse", wr_pulse, p);
    @(negedge clk);
    chk("wr_pulse_once", wr_pulse, '0);
    for (int i = 0; i < b_hold; i++) begin
      if (i > 0) @(negedge clk);
      chk("bhold_bvalid", bvalid, 1'b1);
      chk("bhold_bresp", bresp, (idx < NRW) ? 2'b00 : ERR);
      chk("bhold_awready", awready, 1'b0);
      chk("bhold_wready", wready, 1'b0);
    end
    bready = 1'b1;
    t = 0;
    while (bvalid && t < 20) begin @(negedge clk); t++; end
    chk("b_drain", bvalid, 1'b0);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int r_hold);
    int idx, t;
    logic done, go;
    logic [33:0] e;
    idx = int'(addr[AW-1:2]);
    e = exp_rd(idx);
    rq.push_back(e);
    rready = (r_hold == 0);
    araddr = addr; arvalid = 1'b1;
    done = 1'b0; t = 0;
    while (!done && t < 20) begin
      go = arready;
      @(posedge clk); @(negedge clk); t++;
      if (go) begin arvalid = 1'b0; done = 1'b1; end
    end
    chk("rd_handshake", done, 1'b1);
    chk("rvalid_latency", rvalid, 1'b1);
    for (int i = 0; i < r_hold; i++) begin
      if (i > 0) @(negedge clk);
      chk("rhold_rvalid", rvalid, 1'b1);
      chk("rhold_rdata", rdata, e[31:0]);
      chk("rhold_arready", arready, 1'b0);
    end
    rready = 1'b1;
    t = 0;
    while (rvalid && t < 20) begin @(negedge clk); t++; end
    chk("r_drain", rvalid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    wdata = '0; wstrb = '0;
    status_in = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'hCAFE_F00D};
    for (int i = 0; i < NRW; i++) model[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("rst_awready", awready, 1'b1);
    chk("rst_wready", wready, 1'b1);
    chk("rst_arready", arready, 1'b1);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, '0);
    chk("rst_pulse", wr_pulse, '0);
    chk("rst_reg_out", reg_out == '0, 1'b1);

    for (int i = 0; i < 4; i++) axi_write(AW'(i*4), 32'(i+1), 4'hF, 0);
    for (int i = 0; i < 4; i++) axi_read(AW'(i*4), 0);
    chk("reg_out_low", reg_out[127:0], 128'h00000004_00000003_00000002_00000001);

    axi_write(7'h10, 32'hFFFF_FFFF, 4'hF, 0);
    axi_write(7'h10, 32'h0000_00AB, 4'b0001, 0);
    axi_read(7'h10, 0);
    axi_write(7'h10, 32'h1234_5678, 4'h0, 0);
    axi_read(7'h10, 0);

    // W presented three cycles ahead of AW.
    for (int b = 0; b < 4; b++) model[2][b*8 +: 8] = 8'(32'h55 >> (b*8));
    bq.push_back(2'b00);
    wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
    chk("wfirst_wready", wready, 1'b1);
    @(posedge clk); @(negedge clk); wvalid = 1'b0;
    chk("wfirst_wready_drop", wready, 1'b0);
    repeat (2) @(negedge clk);
    chk("wfirst_no_bvalid", bvalid, 1'b0);
    awaddr = 7'h08; awvalid = 1'b1;
    chk("wfirst_awready", awready, 1'b1);
    @(posedge clk); @(negedge clk); awvalid = 1'b0;
    chk("wfirst_bvalid", bvalid, 1'b1);
    chk("wfirst_pulse", wr_pulse, 12'b0000_0000_0100);
    @(negedge clk);
    chk("wfirst_b_done", bvalid, 1'b0);
    axi_read(7'h08, 0);

    axi_read(7'h30, 0);
    axi_write(7'h30, 32'h1234_5678, 4'hF, 0);
    axi_read(7'h30, 0);
    axi_read(7'h40, 0);
    axi_write(7'h44, 32'hDEAD_BEEF, 4'hF, 0);
    chk("oor_reg_out", reg_out[127:0], 128'h00000004_00000055_00000002_00000001);

    axi_write(7'h14, 32'hA5A5_0001, 4'hF, 5);
    axi_write(7'h18, 32'h5A5A_0002, 4'hF, 0);
    axi_read(7'h14, 5);
    axi_read(7'h18, 0);

    // Reset lands after the AW handshake but before W is ever presented.
    awaddr = 7'h04; awvalid = 1'b1;
    @(posedge clk); @(negedge clk); awvalid = 1'b0;
    chk("mid_aw_held", awready, 1'b0);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < NRW; i++) model[i] = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_no_bvalid", bvalid, 1'b0);
    end
    chk("mid_awready", awready, 1'b1);
    chk("mid_wready", wready, 1'b1);
    for (int i = 0; i < NRW; i++) axi_read(AW'(i*4), 0);
    axi_write(7'h04, 32'h0000_0077, 4'hF, 0);
    axi_read(7'h04, 0);

    repeat (3) @(negedge clk);
    chk("rq_empty", rq.size(), 0);
    chk("bq_empty", bq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
